// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the loader/core memory arbiter.
// Optional feature macro: ARB_ROUND_ROBIN_EN (see mem_arbiter.sv).
package mem_arb_pkg;

  localparam int unsigned DEF_AW = 32;
  localparam int unsigned DEF_DW = 32;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam logic MST_LD  = 1'b0;
  localparam logic MST_ARM = 1'b1;

  // Access-type bits latched at grant and forwarded to the RAM.
  typedef struct packed {
    logic we;
    logic oe;
  } ram_ctl_t;

endpackage

// File: rtl/mem_arb_timer.sv
// Access timeout counter: cleared at grant, counts stalled ACCESS cycles.
module mem_arb_timer
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiry is flagged in the last allowed ACCESS cycle.
  assign expired_c = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Registered two-master (loader, core) to single basic_ram arbiter with timeout.
// ARB_ROUND_ROBIN_EN: alternate grants on simultaneous requests; default is loader priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW      = DEF_AW,
  parameter int unsigned DW      = DEF_DW,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_cs,
  input  logic          ld_we,
  input  logic          ld_oe,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_d_in,
  output logic [DW-1:0] ld_d_out,
  output logic          ld_ready,
  input  logic          arm_cs,
  input  logic          arm_we,
  input  logic          arm_oe,
  input  logic [AW-1:0] arm_addr,
  input  logic [DW-1:0] arm_d_in,
  output logic [DW-1:0] arm_d_out,
  output logic          arm_ready,
  output logic          ram_cs,
  output logic          ram_we,
  output logic          ram_oe,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_d_in,
  input  logic [DW-1:0] ram_d_out,
  input  logic          ram_ready,
  output logic          err
);

  arb_state_e    state_q, state_d;
  logic          win_q, win_d;
  logic          ram_cs_q, ram_cs_d;
  ram_ctl_t      ctl_q, ctl_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_d_in_q, ram_d_in_d;
  logic [DW-1:0] ld_d_out_q, ld_d_out_d;
  logic [DW-1:0] arm_d_out_q, arm_d_out_d;
  logic          ld_ready_q, ld_ready_d;
  logic          arm_ready_q, arm_ready_d;
  logic          err_q, err_d;

  logic          grant_arm;
  logic          tmr_clr;
  logic          tmr_en;
  logic          tmr_expired;
  logic          done;
  logic          timed_out;
  logic [DW-1:0] rdata;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_q, last_grant_d;
`endif

  mem_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr       (tmr_clr),
    .en        (tmr_en),
    .expired_c (tmr_expired)
  );

  // Winner selection; only consulted in IDLE.
  always_comb begin
    grant_arm = arm_cs;
    if (ld_cs && arm_cs) begin
`ifdef ARB_ROUND_ROBIN_EN
      grant_arm = (last_grant_q == MST_LD);
`else
      grant_arm = 1'b0;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    ram_cs_d    = ram_cs_q;
    ctl_d       = ctl_q;
    ram_addr_d  = ram_addr_q;
    ram_d_in_d  = ram_d_in_q;
    ld_d_out_d  = ld_d_out_q;
    arm_d_out_d = arm_d_out_q;
    ld_ready_d  = 1'b0;
    arm_ready_d = 1'b0;
    err_d       = err_q;
    tmr_clr     = 1'b0;
    tmr_en      = 1'b0;
    done        = 1'b0;
    timed_out   = 1'b0;
    rdata       = '0;
`ifdef ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif

    case (state_q)
      IDLE: begin
        if (ld_cs || arm_cs) begin
          win_d      = grant_arm ? MST_ARM : MST_LD;
          ram_cs_d   = 1'b1;
          ctl_d.we   = grant_arm ? arm_we : ld_we;
          ctl_d.oe   = grant_arm ? arm_oe : ld_oe;
          ram_addr_d = grant_arm ? arm_addr : ld_addr;
          ram_d_in_d = grant_arm ? arm_d_in : ld_d_in;
          tmr_clr    = 1'b1;
          state_d    = ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
          last_grant_d = grant_arm ? MST_ARM : MST_LD;
`endif
        end
      end
      ACCESS: begin
        // ram_ready takes precedence over a coincident timeout.
        if (ram_ready) begin
          done  = 1'b1;
          rdata = ctl_q.we ? '0 : ram_d_out;
          err_d = 1'b0;
        end else if (tmr_expired) begin
          done      = 1'b1;
          timed_out = 1'b1;
          err_d     = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
        if (done) begin
          ram_cs_d = 1'b0;
          state_d  = RESP;
          if (win_q == MST_ARM) begin
            arm_d_out_d = timed_out ? '0 : rdata;
            arm_ready_d = 1'b1;
          end else begin
            ld_d_out_d = timed_out ? '0 : rdata;
            ld_ready_d = 1'b1;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        ram_cs_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      win_q       <= MST_LD;
      ram_cs_q    <= 1'b0;
      ctl_q       <= '0;
      ram_addr_q  <= '0;
      ram_d_in_q  <= '0;
      ld_d_out_q  <= '0;
      arm_d_out_q <= '0;
      ld_ready_q  <= 1'b0;
      arm_ready_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      ram_cs_q    <= ram_cs_d;
      ctl_q       <= ctl_d;
      ram_addr_q  <= ram_addr_d;
      ram_d_in_q  <= ram_d_in_d;
      ld_d_out_q  <= ld_d_out_d;
      arm_d_out_q <= arm_d_out_d;
      ld_ready_q  <= ld_ready_d;
      arm_ready_q <= arm_ready_d;
      err_q       <= err_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= MST_ARM;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  assign ld_d_out  = ld_d_out_q;
  assign ld_ready  = ld_ready_q;
  assign arm_d_out = arm_d_out_q;
  assign arm_ready = arm_ready_q;
  assign ram_cs    = ram_cs_q;
  assign ram_we    = ctl_q.we;
  assign ram_oe    = ctl_q.oe;
  assign ram_addr  = ram_addr_q;
  assign ram_d_in  = ram_d_in_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small behavioural basic_ram (TIMEOUT=4).
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          ld_cs, ld_we, ld_oe;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_d_in, ld_d_out;
  logic          ld_ready;
  logic          arm_cs, arm_we, arm_oe;
  logic [AW-1:0] arm_addr;
  logic [DW-1:0] arm_d_in, arm_d_out;
  logic          arm_ready;
  logic          ram_cs, ram_we, ram_oe;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_d_in;
  logic [DW-1:0] ram_d_out = '0;
  logic          ram_ready;
  logic          err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .ld_cs     (ld_cs),
    .ld_we     (ld_we),
    .ld_oe     (ld_oe),
    .ld_addr   (ld_addr),
    .ld_d_in   (ld_d_in),
    .ld_d_out  (ld_d_out),
    .ld_ready  (ld_ready),
    .arm_cs    (arm_cs),
    .arm_we    (arm_we),
    .arm_oe    (arm_oe),
    .arm_addr  (arm_addr),
    .arm_d_in  (arm_d_in),
    .arm_d_out (arm_d_out),
    .arm_ready (arm_ready),
    .ram_cs    (ram_cs),
    .ram_we    (ram_we),
    .ram_oe    (ram_oe),
    .ram_addr  (ram_addr),
    .ram_d_in  (ram_d_in),
    .ram_d_out (ram_d_out),
    .ram_ready (ram_ready),
    .err       (err)
  );

  // basic_ram stand-in: ram_lat = ACCESS cycles before mem_done, 0 = never.
  logic [DW-1:0] mem [256];
  int   ram_lat  = 1;
  int   wait_cnt = 0;
  logic rdy_m    = 1'b0;
  logic late_rdy = 1'b0;
  assign ram_ready = rdy_m | late_rdy;

  always @(negedge clk) begin
    if (ram_cs && !rdy_m && ram_lat != 0) begin
      wait_cnt = wait_cnt + 1;
      if (wait_cnt >= ram_lat) begin
        rdy_m = 1'b1;
        if (ram_we) begin
          mem[ram_addr[7:0]] = ram_d_in;
          ram_d_out = 32'hDEAD_BEEF;
        end else begin
          ram_d_out = mem[ram_addr[7:0]];
        end
      end
    end else begin
      rdy_m = 1'b0;
      if (!ram_cs) wait_cnt = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Tick until the wanted master's ready is seen, recording cycles and stray pulses.
  task automatic run_until_ready(input bit want_arm, input int max_cyc,
                                 output int cyc, output bit other_seen);
    cyc = 0;
    other_seen = 1'b0;
    do begin
      tick();
      cyc++;
      if (want_arm ? ld_ready : arm_ready) other_seen = 1'b1;
    end while (!(want_arm ? arm_ready : ld_ready) && cyc < max_cyc);
  endtask

  int   cyc;
  bit   other;
  bit   first_arm;
  logic [31:0] exp_data [3];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h20] = 32'h1111_1111;
    mem[8'h24] = 32'h2222_2222;
    mem[8'h40] = 32'hA0A0_0001;
    mem[8'h44] = 32'hB0B0_0002;
    mem[8'h48] = 32'hC0C0_0003;

    rst = 1'b1;
    ld_cs = 0; ld_we = 0; ld_oe = 0; ld_addr = '0; ld_d_in = '0;
    arm_cs = 0; arm_we = 0; arm_oe = 0; arm_addr = '0; arm_d_in = '0;
    repeat (3) tick();
    check("rst_ram_cs", ram_cs, 0);
    check("rst_ld_ready", ld_ready, 0);
    check("rst_arm_ready", arm_ready, 0);
    check("rst_err", err, 0);
    check("rst_arm_d_out", arm_d_out, 0);
    rst = 1'b0;
    tick();

    // Loader write 0x10, RAM ready after 2 cycles.
    ram_lat = 2;
    ld_cs = 1; ld_we = 1; ld_oe = 0; ld_addr = 32'h10; ld_d_in = 32'hE3A0_0001;
    tick();
    check("wr_ram_cs", ram_cs, 1);
    check("wr_ram_we", ram_we, 1);
    check("wr_ram_addr", ram_addr, 32'h10);
    check("wr_ram_d_in", ram_d_in, 32'hE3A0_0001);
    run_until_ready(1'b0, 10, cyc, other);
    check("wr_ld_ready", ld_ready, 1);
    check("wr_latency", cyc, 2);
    check("wr_err", err, 0);
    check("wr_arm_quiet", other, 0);
    check("wr_ld_d_out_zero", ld_d_out, 0);
    check("wr_ram_cs_drop", ram_cs, 0);
    ld_cs = 0; ld_we = 0;
    tick();
    check("wr_ready_pulse", ld_ready, 0);

    // Simultaneous reads: loader 0x20, core 0x24.
`ifdef ARB_ROUND_ROBIN_EN
    first_arm = 1'b1;
`else
    first_arm = 1'b0;
`endif
    ram_lat = 1;
    ld_cs = 1; ld_oe = 1; ld_addr = 32'h20;
    arm_cs = 1; arm_oe = 1; arm_addr = 32'h24;
    run_until_ready(first_arm, 10, cyc, other);
    check("both_first_ready", first_arm ? arm_ready : ld_ready, 1);
    check("both_first_data", first_arm ? arm_d_out : ld_d_out,
          first_arm ? 32'h2222_2222 : 32'h1111_1111);
    check("both_first_excl", other, 0);
    if (first_arm) arm_cs = 0; else ld_cs = 0;
    run_until_ready(!first_arm, 10, cyc, other);
    check("both_second_ready", first_arm ? ld_ready : arm_ready, 1);
    check("both_ld_data", ld_d_out, 32'h1111_1111);
    check("both_arm_data", arm_d_out, 32'h2222_2222);
    ld_cs = 0; arm_cs = 0;
    tick();

    // Core reads back the loader's word; loader data unchanged.
    arm_cs = 1; arm_we = 0; arm_oe = 1; arm_addr = 32'h10;
    run_until_ready(1'b1, 10, cyc, other);
    check("rd_arm_ready", arm_ready, 1);
    check("rd_arm_d_out", arm_d_out, 32'hE3A0_0001);
    check("rd_ld_d_out", ld_d_out, 32'h1111_1111);
    check("rd_ld_quiet", other, 0);
    arm_cs = 0;
    tick();

    // RAM never answers: abort after 4 ACCESS cycles.
    ram_lat = 0;
    arm_cs = 1; arm_oe = 1; arm_addr = 32'h30;
    tick();
    check("to_ram_cs", ram_cs, 1);
    run_until_ready(1'b1, 10, cyc, other);
    check("to_arm_ready", arm_ready, 1);
    check("to_cycles", cyc, 4);
    check("to_err", err, 1);
    check("to_arm_d_out", arm_d_out, 0);
    check("to_ram_cs_drop", ram_cs, 0);
    arm_cs = 0;
    tick();
    check("to_err_hold", err, 1);
    check("to_ready_pulse", arm_ready, 0);

    // Reset in the middle of an access, then a stray late ram_ready.
    ld_cs = 1; ld_we = 0; ld_oe = 1; ld_addr = 32'h20;
    tick();
    tick();
    check("rs_in_access", ram_cs, 1);
    rst = 1; ld_cs = 0;
    tick();
    check("rs_ram_cs", ram_cs, 0);
    check("rs_ld_ready", ld_ready, 0);
    check("rs_arm_ready", arm_ready, 0);
    check("rs_err", err, 0);
    rst = 0;
    tick();
    late_rdy = 1;
    tick();
    late_rdy = 0;
    tick();
    check("late_ld_ready", ld_ready, 0);
    check("late_arm_ready", arm_ready, 0);
    check("late_ram_cs", ram_cs, 0);
    ram_lat = 1;
    ld_cs = 1;
    run_until_ready(1'b0, 10, cyc, other);
    check("post_rst_ready", ld_ready, 1);
    check("post_rst_data", ld_d_out, 32'h1111_1111);
    check("post_rst_err", err, 0);
    ld_cs = 0;
    tick();

    // Core holds cs through three back-to-back reads.
    exp_data[0] = 32'hA0A0_0001;
    exp_data[1] = 32'hB0B0_0002;
    exp_data[2] = 32'hC0C0_0003;
    arm_cs = 1; arm_oe = 1; arm_addr = 32'h40;
    for (int i = 0; i < 3; i++) begin
      run_until_ready(1'b1, 20, cyc, other);
      check($sformatf("b2b_ready%0d", i), arm_ready, 1);
      check($sformatf("b2b_data%0d", i), arm_d_out, exp_data[i]);
      check($sformatf("b2b_period%0d", i), cyc, (i == 0) ? 2 : 3);
      arm_addr = arm_addr + 32'h4;
    end
    arm_cs = 0;
    tick();
    check("b2b_pulse_end", arm_ready, 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
